// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - IF/MEM arbiter for a single-ported unified memory
// MEM wins ties until STARVE_MAX consecutive MEM grants have passed a waiting IF.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                pipe_stall,
  output logic                busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          grant_i, grant_d, ack_i, ack_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // streak only counts MEM grants that overtook a waiting IF
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    ack_i      = 1'b0;
    ack_d      = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (!if_req || streak < STREAK_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = GNT_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = GNT_I;
        end
        if (!if_req || grant_i) begin
          streak_nxt = '0;
        end else if (grant_d) begin
          streak_nxt = streak + 1'b1;
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          ack_i     = 1'b1;
          state_nxt = RESP;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          ack_d     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      if_done <= ack_i;
      dm_done <= ack_d;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
      if (ack_i || ack_d) begin
        mem_req <= 1'b0;
      end
      if (ack_i) begin
        if_rdata <= mem_rdata;
      end
      // stores leave the last load value visible to the MEM stage
      if (ack_d && !mem_we) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

  assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - randomized scoreboard bench for mips_mem_arbiter
module tb_mips_mem_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        pipe_stall;
  logic        busy;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pipe_stall(pipe_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instruction region 0x000-0x0FF is read-only; data region starts at 0x100
  logic [31:0] rom [64];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] ref_ram [logic [31:0]];
  int unsigned wait_min = 0;
  int unsigned wait_max = 3;
  bit          mem_auto = 1'b1;
  bit          force_ack = 1'b0;

  typedef struct packed { logic st; logic [31:0] data; } dm_exp_t;
  logic [31:0] if_q [$];
  dm_exp_t     dm_q [$];
  logic [31:0] last_fetch = '0;
  logic [31:0] last_load = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 32'h0;
  endfunction

  // memory model: acks each request after a random number of wait cycles
  initial begin : memory
    int unsigned wcnt;
    bit in_xfer;
    wcnt = 0;
    in_xfer = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_auto && mem_req) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          wcnt = $urandom_range(wait_max, wait_min);
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          in_xfer = 1'b0;
          if (mem_we) ram[mem_addr] = merge(ram_rd(mem_addr), mem_wdata, mem_be);
          else mem_rdata = (mem_addr < 32'h100) ? rom[mem_addr[7:2]] : ram_rd(mem_addr);
        end else begin
          wcnt--;
        end
      end else begin
        in_xfer = 1'b0;
      end
    end
  end

  // grant checker: reference arbitration and attribute stability
  initial begin : grants
    bit pmr, win_d;
    int streak_m;
    logic [31:0] ea, ewd;
    logic [3:0] ebe;
    logic ewe;
    pmr = 1'b0; win_d = 1'b0; streak_m = 0;
    ea = '0; ewd = '0; ebe = '0; ewe = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        streak_m = 0;
        pmr = 1'b0;
      end else begin
        if (mem_req && !pmr) begin
          if (!if_req && !dm_req) begin
            fail("grant_without_request");
          end else begin
            win_d = dm_req && (!if_req || streak_m < SMAX);
            streak_m = (if_req && win_d) ? streak_m + 1 : 0;
            ea  = win_d ? dm_addr : if_addr;
            ewe = win_d ? dm_we : 1'b0;
            ebe = win_d ? dm_be : 4'hF;
            ewd = dm_wdata;
            check("grant_addr", mem_addr, ea);
            check1("grant_we", mem_we, ewe);
            check("grant_be", 32'(mem_be), 32'(ebe));
            if (win_d) check("grant_wdata", mem_wdata, ewd);
          end
        end else if (mem_req) begin
          check("hold_addr", mem_addr, ea);
          check1("hold_we", mem_we, ewe);
          check("hold_be", 32'(mem_be), 32'(ebe));
          if (win_d) check("hold_wdata", mem_wdata, ewd);
        end
        pmr = mem_req;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    bit pif, pdm;
    logic [31:0] e;
    dm_exp_t d;
    pif = 1'b0; pdm = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check1("pipe_stall", pipe_stall, (if_req & ~if_done) | (dm_req & ~dm_done));
        if (if_done) begin
          check1("if_done_single", pif, 1'b0);
          if (if_q.size() == 0) fail("if_done_unexpected");
          else begin
            e = if_q.pop_front();
            last_fetch = e;
            check("if_rdata", if_rdata, e);
          end
        end
        if (dm_done) begin
          check1("dm_done_single", pdm, 1'b0);
          if (dm_q.size() == 0) fail("dm_done_unexpected");
          else begin
            d = dm_q.pop_front();
            if (!d.st) last_load = d.data;
            check(d.st ? "dm_rdata_after_store" : "dm_rdata_load", dm_rdata, last_load);
          end
        end
      end
      pif = if_done;
      pdm = dm_done;
    end
  end

  task automatic issue_if(input logic [31:0] a);
    if_addr = a;
    if_req = 1'b1;
    if_q.push_back(rom[a[7:2]]);
  endtask

  task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be; dm_req = 1'b1;
    if (we) begin
      ref_ram[a] = merge(ref_rd(a), wd, be);
      dm_q.push_back('{st: 1'b1, data: 32'h0});
    end else begin
      dm_q.push_back('{st: 1'b0, data: ref_rd(a)});
    end
  endtask

  task automatic wait_done(input bit d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? dm_done : if_done) && n < 300);
    if (!(d ? dm_done : if_done)) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: no pulse after %0d cycles, required one", d ? "dm" : "if", n);
    end
  endtask

  task automatic run_if(input int n, input int gap_max);
    int c;
    for (int k = 0; k < n; k++) begin
      issue_if(32'($urandom_range(63, 0)) << 2);
      wait_done(1'b0, c);
      #1;
      if (gap_max > 0 && $urandom_range(1, 0) == 1) begin
        if_req = 1'b0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
        #1;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic run_dm(input int n, input int gap_max);
    int c;
    for (int k = 0; k < n; k++) begin
      issue_dm(1'($urandom_range(1, 0)), 32'h100 + (32'($urandom_range(15, 0)) << 2),
               $urandom, 4'($urandom_range(15, 0)));
      wait_done(1'b1, c);
      #1;
      if (gap_max > 0 && $urandom_range(1, 0) == 1) begin
        dm_req = 1'b0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
        #1;
      end
    end
    dm_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stim
    int n, n2;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[16] = 32'h8C01_0004;

    // reset with both requests pending
    issue_if(32'h80);
    issue_dm(1'b0, 32'h104, 32'h0, 4'h0);
    repeat (2) begin
      @(negedge clk);
      check1("rst_mem_req", mem_req, 1'b0);
      check1("rst_if_done", if_done, 1'b0);
      check1("rst_dm_done", dm_done, 1'b0);
      check1("rst_busy", busy, 1'b0);
    end
    #1 reset = 1'b1;
    fork
      begin wait_done(1'b0, n); #1 if_req = 1'b0; end
      begin wait_done(1'b1, n2); #1 dm_req = 1'b0; end
    join

    // single zero-wait IF read
    wait_min = 0; wait_max = 0;
    @(negedge clk); #1;
    issue_if(32'h40);
    wait_done(1'b0, n);
    check("if_latency", 32'(n), 32'd2);
    check("if_fetch_value", if_rdata, 32'h8C01_0004);
    #1 if_req = 1'b0;

    // store with four wait states, then read it back
    wait_min = 4; wait_max = 4;
    @(negedge clk); #1;
    issue_dm(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    wait_done(1'b1, n);
    check("store_latency", 32'(n), 32'd6);
    #1 dm_req = 1'b0;
    wait_min = 0; wait_max = 1;
    @(negedge clk); #1;
    issue_dm(1'b0, 32'h100, 32'h0, 4'h0);
    wait_done(1'b1, n);
    check("store_merge", dm_rdata, 32'h0000_BEEF);
    #1 dm_req = 1'b0;

    // spurious ack in IDLE
    @(negedge clk); #1 force_ack = 1'b1;
    @(negedge clk); #1 force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check1("spur_if_done", if_done, 1'b0);
      check1("spur_dm_done", dm_done, 1'b0);
      check("spur_if_rdata", if_rdata, last_fetch);
      check("spur_dm_rdata", dm_rdata, last_load);
    end

    // contention: both stages continuously reasserting
    wait_min = 0; wait_max = 2;
    #1;
    fork
      run_if(10, 0);
      run_dm(45, 0);
    join

    // reset while MEM access is outstanding, late ack afterwards
    mem_auto = 1'b0;
    @(negedge clk); #1;
    dm_we = 1'b0; dm_addr = 32'h108; dm_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 20);
    check1("abort_granted", mem_req, 1'b1);
    #1 reset = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check1("abort_mem_req", mem_req, 1'b0);
    check1("abort_busy", busy, 1'b0);
    #1 reset = 1'b1;
    @(negedge clk); #1 force_ack = 1'b1;
    @(negedge clk); #1 force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check1("abort_no_done", dm_done, 1'b0);
      check1("abort_idle", busy, 1'b0);
      check("abort_dm_rdata", dm_rdata, last_load);
    end
    mem_auto = 1'b1;
    #1;
    issue_dm(1'b0, 32'h100, 32'h0, 4'h0);
    wait_done(1'b1, n);
    #1 dm_req = 1'b0;

    // random traffic
    wait_min = 0; wait_max = 3;
    @(negedge clk); #1;
    fork
      run_if(40, 4);
      run_dm(60, 4);
    join
    repeat (5) @(negedge clk);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
